// File: rtl/alu_share_arbiter_pkg.sv
// alu_share_arbiter_pkg
//   Shared definitions for the ALU sharing arbiter: FSM state encodings,
//   the largest supported requester count and the ALUop code space used
//   by the shared ALU.
//   No ports (package).
package alu_share_arbiter_pkg;

    localparam int ARB_MAX_NREQ = 8;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_EXEC = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    // Codes not listed here are still forwarded to the ALU untouched; the
    // ALU answers them with 0.
    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_AND    = 5'd2,
        ALU_OR     = 5'd3,
        ALU_XOR    = 5'd4,
        ALU_SLL    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_SLT    = 5'd8,
        ALU_SLTU   = 5'd9,
        ALU_COPY_B = 5'd10
    } alu_op_e;

endpackage

// File: rtl/alu_share_arbiter_rr.sv
// alu_share_arbiter_rr
//   Combinational round-robin picker. The search starts one position after
//   ptr (wrapping at NREQ) and the first asserted request wins.
//   Ports:
//     req  in  NREQ  request vector
//     ptr  in  IDW   index of the most recent winner
//     en   in  1     grant enable; gnt is all-zero when low
//     gnt  out NREQ  one-hot grant (zero when en=0 or no request)
//     idx  out IDW   binary index of the winner (valid whenever any req is set)
module alu_share_arbiter_rr #(
    parameter  int NREQ = 3,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx
);

    // One spare bit so ptr + offset never overflows before the wrap.
    logic [IDW:0] cand;
    logic         found;

    always_comb begin
        cand  = '0;
        found = 1'b0;
        idx   = '0;
        for (int off = 1; off <= NREQ; off++) begin
            cand = {1'b0, ptr} + (IDW+1)'(off);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (!found && req[cand[IDW-1:0]]) begin
                found = 1'b1;
                idx   = cand[IDW-1:0];
            end
        end
        gnt = '0;
        if (found && en) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one external combinational 32-bit ALU between NREQ requesters.
//   A round-robin winner's op/operands are registered into the ALU, the
//   result is captured one cycle later and returned on a single response
//   channel tagged with the winner's index.
//   Build option: define ALU_ARB_PERF_EN to get per-requester 32-bit grant
//   counters on perf_grant; otherwise perf_grant is tied to zero.
//   Ports:
//     clk, rst                    clock, synchronous active-high reset
//     req_valid/req_ready         per-requester handshake (ready one-hot or 0)
//     req_op/req_a/req_b          packed per-requester ALUop and operands
//     alu_op/alu_a/alu_b/alu_out  registered ALU inputs, combinational result
//     rsp_valid/rsp_ready         response handshake
//     rsp_id/rsp_data             owner index and captured result
//     perf_grant                  packed per-requester grant counters
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ARB_IDLE | nothing in flight; any valid request is granted at once
//   ARB_EXEC | ALU inputs hold the granted op; result captured this cycle
//   ARB_RESP | rsp_valid high; accept may overlap the next grant
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter  int NREQ = 3,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [5*NREQ-1:0]  req_op,
    input  logic [32*NREQ-1:0] req_a,
    input  logic [32*NREQ-1:0] req_b,
    output logic [4:0]         alu_op,
    output logic [31:0]        alu_a,
    output logic [31:0]        alu_b,
    input  logic [31:0]        alu_out,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [31:0]        rsp_data,
    output logic [32*NREQ-1:0] perf_grant
);

    if (NREQ < 2 || NREQ > ARB_MAX_NREQ) begin : g_bad_nreq
        $error("alu_share_arbiter: NREQ must be in 2..%0d", ARB_MAX_NREQ);
    end

    arb_state_e       state_q;
    arb_state_e       state_d;
    logic [IDW-1:0]   ptr_q;
    logic             arb_en;
    logic             capture;
    logic [NREQ-1:0]  gnt;
    logic [IDW-1:0]   gidx;
    logic             xfer;
    logic [4:0]       sel_op;
    logic [31:0]      sel_a;
    logic [31:0]      sel_b;
    logic [4:0]       alu_op_q;
    logic [31:0]      alu_a_q;
    logic [31:0]      alu_b_q;
    logic [IDW-1:0]   rsp_id_q;
    logic [31:0]      rsp_data_q;

    alu_share_arbiter_rr #(.NREQ(NREQ)) u_rr (
        .req (req_valid),
        .ptr (ptr_q),
        .en  (arb_en),
        .gnt (gnt),
        .idx (gidx)
    );

    assign req_ready = gnt;
    assign xfer      = |(req_valid & req_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: if (xfer) state_d = ARB_EXEC;
            ARB_EXEC: state_d = ARB_RESP;
            ARB_RESP: if (rsp_ready) state_d = xfer ? ARB_EXEC : ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    // Granting in RESP is only allowed when the pending response leaves in
    // the same cycle, so the single result register is never overwritten.
    always_comb begin
        arb_en    = (state_q == ARB_IDLE) || ((state_q == ARB_RESP) && rsp_ready);
        capture   = (state_q == ARB_EXEC);
        rsp_valid = (state_q == ARB_RESP);
    end

    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gidx == IDW'(i)) begin
                sel_op = req_op[5*i +: 5];
                sel_a  = req_a[32*i +: 32];
                sel_b  = req_b[32*i +: 32];
            end
        end
    end

    // rsp_id may be loaded on a RESP-state grant because that grant only
    // happens while the current response is being accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_op_q   <= ALU_COPY_B;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            ptr_q      <= IDW'(NREQ - 1);
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
        end else begin
            if (xfer) begin
                alu_op_q <= sel_op;
                alu_a_q  <= sel_a;
                alu_b_q  <= sel_b;
                ptr_q    <= gidx;
                rsp_id_q <= gidx;
            end
            if (capture) begin
                rsp_data_q <= alu_out;
            end
        end
    end

    assign alu_op   = alu_op_q;
    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign rsp_id   = rsp_id_q;
    assign rsp_data = rsp_data_q;

`ifdef ALU_ARB_PERF_EN
    logic [31:0] grant_cnt_q [NREQ];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                grant_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (xfer && (gidx == IDW'(i))) begin
                    grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
                end
            end
        end
    end

    always_comb begin
        perf_grant = '0;
        for (int i = 0; i < NREQ; i++) begin
            perf_grant[32*i +: 32] = grant_cnt_q[i];
        end
    end
`else
    assign perf_grant = '0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
//   Self-checking bench: directed vector table, hand-written multi-cycle
//   sequences, then randomized traffic against a transaction-level model.
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    localparam int NREQ = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [5*NREQ-1:0]  req_op;
    logic [32*NREQ-1:0] req_a;
    logic [32*NREQ-1:0] req_b;
    logic [4:0]         alu_op;
    logic [31:0]        alu_a;
    logic [31:0]        alu_b;
    logic [31:0]        alu_out;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [1:0]         rsp_id;
    logic [31:0]        rsp_data;
    logic [32*NREQ-1:0] perf_grant;

    logic [4:0]  rq_op [NREQ];
    logic [31:0] rq_a  [NREQ];
    logic [31:0] rq_b  [NREQ];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_share_arbiter #(.NREQ(NREQ)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_out    (alu_out),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .perf_grant (perf_grant)
    );

    function automatic logic [31:0] alu_fn(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        case (op)
            ALU_ADD:    return a + b;
            ALU_SUB:    return a - b;
            ALU_AND:    return a & b;
            ALU_OR:     return a | b;
            ALU_XOR:    return a ^ b;
            ALU_SLL:    return a << b[4:0];
            ALU_SRL:    return a >> b[4:0];
            ALU_SRA:    return $signed(a) >>> b[4:0];
            ALU_SLT:    return {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU:   return {31'b0, a < b};
            ALU_COPY_B: return b;
            default:    return 32'h0;
        endcase
    endfunction

    // Stand-in for the shared ALU that the parent would instantiate.
    always_comb alu_out = alu_fn(alu_op, alu_a, alu_b);

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_op[5*i +: 5]  = rq_op[i];
            req_a[32*i +: 32] = rq_a[i];
            req_b[32*i +: 32] = rq_b[i];
        end
    end

    function automatic logic [NREQ-1:0] onehot(input int i);
        return NREQ'(1 << i);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        req_valid = '0;
        step();
        rst = 1'b0;
    endtask

    // One isolated request from an idle arbiter with rsp_ready held high.
    task automatic issue_single(input int id, input logic [4:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] exp);
        req_valid = onehot(id);
        rq_op[id] = op;
        rq_a[id]  = a;
        rq_b[id]  = b;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("single_ready", 32'(req_ready), 32'(onehot(id)));
        check("single_rsp_low_accept", 32'(rsp_valid), 32'd0);
        step();
        req_valid = '0;
        @(negedge clk);
        check("single_rsp_low_exec", 32'(rsp_valid), 32'd0);
        step();
        @(negedge clk);
        check("single_rsp_valid", 32'(rsp_valid), 32'd1);
        check("single_rsp_id", 32'(rsp_id), 32'(id));
        check("single_rsp_data", rsp_data, exp);
        step();
    endtask

    typedef struct {
        int          id;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] data;
    } rsp_t;

    vec_t vecs [11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rsp_t             exp_q[$];
        logic [NREQ-1:0]  acc;
        logic [NREQ-1:0]  exp_ready;
        bit               busy;
        bit               exp_rsp;
        bit               allow;
        bit               found;
        int               acc_cyc;
        int               last;
        int               win;
        int               model_cnt [NREQ];

        vecs[0]  = '{0, ALU_ADD,    32'd5,          32'd7,          32'd12};
        vecs[1]  = '{1, ALU_SUB,    32'd3,          32'd5,          32'hFFFF_FFFE};
        vecs[2]  = '{2, ALU_SRA,    32'h8000_0000,  32'd4,          32'hF800_0000};
        vecs[3]  = '{0, ALU_SLTU,   32'd1,          32'hFFFF_FFFF,  32'd1};
        vecs[4]  = '{1, ALU_AND,    32'h0000_F0F0,  32'h0000_0FF0,  32'h0000_00F0};
        vecs[5]  = '{2, ALU_XOR,    32'hFFFF_0000,  32'h0F0F_0F0F,  32'hF0F0_0F0F};
        vecs[6]  = '{0, ALU_SLL,    32'd1,          32'd31,         32'h8000_0000};
        vecs[7]  = '{1, ALU_SRL,    32'h8000_0000,  32'd4,          32'h0800_0000};
        vecs[8]  = '{2, ALU_SLT,    32'hFFFF_FFFF,  32'd1,          32'd1};
        vecs[9]  = '{0, ALU_COPY_B, 32'd1,          32'h0000_DEAD,  32'h0000_DEAD};
        vecs[10] = '{1, 5'd31,      32'd5,          32'd6,          32'd0};

        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            rq_op[i] = '0;
            rq_a[i]  = '0;
            rq_b[i]  = '0;
        end
        step();
        step();

        // Reset state
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'(ALU_COPY_B));
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        check("rst_perf", 32'(|perf_grant), 32'd0);
        step();
        rst = 1'b0;

        // Directed vector table (first entry is the post-reset ADD)
        for (int v = 0; v < 11; v++) begin
            issue_single(vecs[v].id, vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].exp);
        end

        // Response held under backpressure; no grant until accepted
        req_valid = onehot(1);
        rq_op[1] = ALU_SUB; rq_a[1] = 32'd3; rq_b[1] = 32'd5;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("hold_grant1", 32'(req_ready), 32'(onehot(1)));
        step();
        req_valid = '0;
        step();
        req_valid = onehot(0);
        rq_op[0] = ALU_ADD; rq_a[0] = 32'd1; rq_b[0] = 32'd1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_id", 32'(rsp_id), 32'd1);
            check("hold_data", rsp_data, 32'hFFFF_FFFE);
            check("hold_no_grant", 32'(req_ready), 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("hold_release_grant", 32'(req_ready), 32'(onehot(0)));
        check("hold_release_valid", 32'(rsp_valid), 32'd1);
        step();
        req_valid = '0;
        @(negedge clk);
        check("b2b_exec_low", 32'(rsp_valid), 32'd0);
        step();
        @(negedge clk);
        check("b2b_valid", 32'(rsp_valid), 32'd1);
        check("b2b_id", 32'(rsp_id), 32'd0);
        check("b2b_data", rsp_data, 32'd2);
        step();

        // Reset while in EXEC discards the op
        req_valid = onehot(2);
        rq_op[2] = ALU_ADD; rq_a[2] = 32'd9; rq_b[2] = 32'd9;
        step();
        req_valid = '0;
        rst = 1'b1;
        step();
        @(negedge clk);
        check("rst_exec_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_exec_req_ready", 32'(req_ready), 32'd0);
        step();
        rst = 1'b0;

        // All requesters continuously valid: 0,1,2,0,... one rsp per 2 cycles
        for (int i = 0; i < NREQ; i++) begin
            rq_op[i] = ALU_ADD;
            rq_a[i]  = 32'(i * 100);
            rq_b[i]  = 32'd1;
        end
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k % 2 == 0) begin
                check("rr_grant", 32'(req_ready), 32'(onehot((k / 2) % 3)));
                if (k >= 2) begin
                    check("rr_rsp_valid", 32'(rsp_valid), 32'd1);
                    check("rr_rsp_id", 32'(rsp_id), 32'(((k / 2) - 1) % 3));
                    check("rr_rsp_data", rsp_data, 32'((((k / 2) - 1) % 3) * 100 + 1));
                end else begin
                    check("rr_rsp_valid", 32'(rsp_valid), 32'd0);
                end
            end else begin
                check("rr_exec_ready", 32'(req_ready), 32'd0);
                check("rr_exec_valid", 32'(rsp_valid), 32'd0);
            end
            step();
        end
        req_valid = '0;
        @(negedge clk);
        check("rr_last_id", 32'(rsp_id), 32'd2);
        check("rr_last_data", rsp_data, 32'd201);
        step();

        // Grant counters
        pulse_reset();
        for (int k = 0; k < 5; k++) begin
            issue_single(1, ALU_ADD, 32'(k), 32'd1, 32'(k + 1));
        end
        @(negedge clk);
`ifdef ALU_ARB_PERF_EN
        check("perf_req1", perf_grant[63:32], 32'd5);
        check("perf_req0", perf_grant[31:0], 32'd0);
        check("perf_req2", perf_grant[95:64], 32'd0);
`else
        check("perf_off_lo", perf_grant[31:0], 32'd0);
        check("perf_off_mid", perf_grant[63:32], 32'd0);
        check("perf_off_hi", perf_grant[95:64], 32'd0);
`endif
        step();

        // Randomized traffic against the transaction model
        pulse_reset();
        busy    = 1'b0;
        acc     = '0;
        acc_cyc = 0;
        last    = NREQ - 1;
        for (int i = 0; i < NREQ; i++) model_cnt[i] = 0;
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
                    req_valid[i] = 1'b1;
                    rq_op[i] = 5'($urandom_range(0, 12));
                    rq_a[i]  = $urandom;
                    rq_b[i]  = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);

            exp_rsp = busy && (cyc - acc_cyc >= 2);
            check("rnd_rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
            if (exp_rsp && exp_q.size() > 0) begin
                check("rnd_rsp_id", 32'(rsp_id), 32'(exp_q[0].id));
                check("rnd_rsp_data", rsp_data, exp_q[0].data);
            end

            allow = !busy || (exp_rsp && rsp_ready);
            found = 1'b0;
            win   = 0;
            for (int off = 1; off <= NREQ; off++) begin
                if (!found && req_valid[(last + off) % NREQ]) begin
                    found = 1'b1;
                    win   = (last + off) % NREQ;
                end
            end
            exp_ready = (allow && found) ? onehot(win) : '0;
            check("rnd_req_ready", 32'(req_ready), 32'(exp_ready));

            if (exp_rsp && rsp_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                busy = 1'b0;
            end
            acc = exp_ready;
            if (allow && found) begin
                busy    = 1'b1;
                acc_cyc = cyc;
                last    = win;
                exp_q.push_back('{win, alu_fn(rq_op[win], rq_a[win], rq_b[win])});
                model_cnt[win]++;
            end
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        step();
        step();
        step();
        @(negedge clk);
        check("rnd_drained", 32'(rsp_valid), 32'd0);
`ifdef ALU_ARB_PERF_EN
        for (int i = 0; i < NREQ; i++) begin
            check("rnd_perf", perf_grant[32*i +: 32], 32'(model_cnt[i]));
        end
`else
        check("rnd_perf_off", 32'(|perf_grant), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
